// File: rtl/regfile_sb.sv
// Parametrised multi-read-port register file with a per-register pending
// scoreboard, used by decode/issue to read operands and stall on producers.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREAD*$clog2(NREGS)-1:0] ra,
  output logic [NREAD*XLEN-1:0]          rd,
  output logic [NREAD-1:0]               rrdy,
  input  logic                          we,
  input  logic [$clog2(NREGS)-1:0]       wa,
  input  logic [XLEN-1:0]                wd,
  input  logic                          mark_en,
  input  logic [$clog2(NREGS)-1:0]       mark_a,
  output logic [$clog2(NREGS+1)-1:0]     pend_cnt
);

  localparam int AW  = $clog2(NREGS);
  localparam int CW  = $clog2(NREGS+1);
  localparam int AWX = AW + 1;
  localparam logic [AW:0] NREGS_X = AWX'(NREGS);

  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] pend;

  logic wr_ok;
  logic mk_ok;
  logic cnt_inc;
  logic cnt_dec;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_X) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Gating with rst_n keeps bypass and updates inert while reset is held.
  assign wr_ok = rst_n && we && addr_ok(wa);
  assign mk_ok = rst_n && mark_en && addr_ok(mark_a);

  // A mark on the written address keeps the bit set, so the clear is not counted.
  assign cnt_inc = mk_ok && !pend[mark_a];
  assign cnt_dec = wr_ok && pend[wa] && !(mk_ok && (mark_a == wa));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) rf[r] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_ok) begin
        rf[wa]   <= wd;
        pend[wa] <= 1'b0;
      end
      if (mk_ok) pend[mark_a] <= 1'b1;
      pend_cnt <= pend_cnt + CW'(cnt_inc) - CW'(cnt_dec);
    end
  end

  always_comb begin
    rd   = '0;
    rrdy = '1;
    for (int i = 0; i < NREAD; i++) begin
      if (addr_ok(ra[i*AW +: AW])) begin
        if ((BYPASS != 0) && wr_ok && (wa == ra[i*AW +: AW])) begin
          rd[i*XLEN +: XLEN] = wd;
          rrdy[i]            = 1'b1;
        end else begin
          rd[i*XLEN +: XLEN] = rf[ra[i*AW +: AW]];
          rrdy[i]            = ~pend[ra[i*AW +: AW]];
        end
      end
    end
  end

endmodule
